// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped responder: word offsets and STATUS layout.
package mmio_pkg;

  // Word offsets inside the 16-byte window (Address[3:2]).
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLES  = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  // STATUS register bit positions.
  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 8;
  localparam int ST_CNT_HI = 15;

endpackage

// File: rtl/mmio_responder_tx_fifo.sv
// Byte transmit FIFO: synchronous pointers, async-reset storage, combinational head.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [0:DEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Advance a pointer modulo DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  always_comb begin
    do_push = push & (~full | pop);
    do_pop  = pop & ~empty;
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry and occupancy flags.
  always_comb begin
    head  = mem[rd_ptr];
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
  end

endmodule

// File: rtl/mmio_responder.sv
// CPU-bus responder: 16-byte window with TXDATA FIFO, STATUS, CYCLES counter and SCRATCH.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h0000_FF00,
  parameter int          DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] WriteDataMem,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          hit_now;
  logic [1:0]    off;
  logic          wr;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [31:0]   cycles;
  logic [31:0]   scratch;
  logic [31:0]   status;
  logic [31:0]   rd_next;
  logic          unused_addr_lsbs;

  // Byte lane select bits are not decoded; words only.
  assign unused_addr_lsbs = ^Address[1:0];

  // Address decode and write/pop strobes.
  always_comb begin
    hit_now = (Address[31:4] == BASE[31:4]);
    off     = Address[3:2];
    wr      = hit_now & MemWrite;
    push    = wr & (off == OFF_TXDATA);
    pop     = out_valid & out_ready;
  end

  tx_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (WriteDataMem[7:0]),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Stream side is driven straight from the FIFO head (no bypass of the write edge).
  always_comb begin
    out_valid = ~empty;
    out_data  = head;
  end

  // Sticky overflow: set on a dropped push, cleared by writing STATUS bit 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr && (off == OFF_STATUS) && WriteDataMem[ST_OVF]) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Free-running cycle counter; a CPU write wins its edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= 32'h0000_0000;
    end else if (wr && (off == OFF_CYCLES)) begin
      cycles <= WriteDataMem;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // Scratch word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch <= 32'h0000_0000;
    end else if (wr && (off == OFF_SCRATCH)) begin
      scratch <= WriteDataMem;
    end
  end

  // STATUS image assembled from the pre-edge FIFO state.
  always_comb begin
    status                      = 32'h0000_0000;
    status[ST_EMPTY]            = empty;
    status[ST_FULL]             = full;
    status[ST_OVF]              = overflow;
    status[ST_CNT_HI:ST_CNT_LO] = 8'(count);
  end

  // Read mux; misses read as zero.
  always_comb begin
    rd_next = 32'h0000_0000;
    if (hit_now) begin
      case (off)
        OFF_TXDATA:  rd_next = 32'h0000_0000;
        OFF_STATUS:  rd_next = status;
        OFF_CYCLES:  rd_next = cycles;
        OFF_SCRATCH: rd_next = scratch;
        default:     rd_next = 32'h0000_0000;
      endcase
    end else begin
      rd_next = 32'h0000_0000;
    end
  end

  // One-cycle registered read path, matching the main memory latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 32'h0000_0000;
      hit     <= 1'b0;
    end else begin
      rd_data <= rd_next;
      hit     <= hit_now;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_FF00;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] WriteDataMem;
  logic [31:0] rd_data;
  logic        hit;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  mmio_responder #(.BASE(BASE), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .MemWrite     (MemWrite),
    .WriteDataMem (WriteDataMem),
    .rd_data      (rd_data),
    .hit          (hit),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus write cycle; returns #1 after the write edge with the bus idle.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address      = addr;
    WriteDataMem = data;
    MemWrite     = 1'b1;
    @(posedge clk); #1;
    MemWrite     = 1'b0;
    Address      = 32'h0000_0000;
  endtask

  // One bus read cycle; samples rd_data/hit #1 after the capturing edge.
  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic h);
    Address  = addr;
    MemWrite = 1'b0;
    @(posedge clk); #1;
    d        = rd_data;
    h        = hit;
    Address  = 32'h0000_0000;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [31:0] d;
  logic        h;

  initial begin
    reset        = 1'b1;
    Address      = 32'h0000_0000;
    MemWrite     = 1'b0;
    WriteDataMem = 32'h0000_0000;
    out_ready    = 1'b0;
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {24'd0, out_data}, 32'd0);
    check("rst_rd",    rd_data, 32'd0);
    check("rst_hit",   {31'd0, hit}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state through STATUS.
    bus_read(BASE + 32'h4, d, h);
    check("status_reset_hit", {31'd0, h}, 32'd1);
    check("status_reset", d, 32'h0000_0001);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_data",  {24'd0, out_data}, 32'd0);
    tick();
    check("miss_hit_idle", {31'd0, hit}, 32'd0);

    // Two pushes, then drain.
    bus_write(BASE, 32'h0000_0041);
    check("nobypass_valid", {31'd0, out_valid}, 32'd1);
    bus_write(BASE, 32'hFFFF_FF42);
    bus_read(BASE + 32'h4, d, h);
    check("status_two", d, 32'h0000_0200);
    check("head_41", {24'd0, out_data}, 32'h41);
    out_ready = 1'b1;
    tick();
    check("head_42", {24'd0, out_data}, 32'h42);
    check("valid_after_pop1", {31'd0, out_valid}, 32'd1);
    tick();
    check("valid_after_pop2", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    bus_read(BASE + 32'h4, d, h);
    check("status_drained", d, 32'h0000_0001);

    // Overflow: fifth byte dropped.
    for (int i = 0; i < 5; i++) bus_write(BASE, 32'h10 + i);
    bus_read(BASE + 32'h4, d, h);
    check("status_ovf", d, 32'h0000_0406);
    bus_write(BASE + 32'h4, 32'h0000_0004);
    bus_read(BASE + 32'h4, d, h);
    check("status_ovf_clr", d, 32'h0000_0402);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_ovf_%0d", i), {24'd0, out_data}, 32'h10 + i);
      tick();
    end
    check("drain_ovf_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Push into full FIFO with simultaneous pop.
    for (int i = 0; i < 4; i++) bus_write(BASE, 32'h20 + i);
    out_ready = 1'b1;
    bus_write(BASE, 32'h0000_0055);
    out_ready = 1'b0;
    bus_read(BASE + 32'h4, d, h);
    check("status_full_pushpop", d, 32'h0000_0402);
    out_ready = 1'b1;
    check("pp_0", {24'd0, out_data}, 32'h21); tick();
    check("pp_1", {24'd0, out_data}, 32'h22); tick();
    check("pp_2", {24'd0, out_data}, 32'h23); tick();
    check("pp_3", {24'd0, out_data}, 32'h55); tick();
    check("pp_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // CYCLES load and wrap.
    bus_write(BASE + 32'h8, 32'hFFFF_FFFE);
    bus_read(BASE + 32'h8, d, h);
    check("cyc_0", d, 32'hFFFF_FFFE);
    bus_read(BASE + 32'h8, d, h);
    check("cyc_1", d, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h8, d, h);
    check("cyc_wrap", d, 32'h0000_0000);

    // SCRATCH, TXDATA read, byte bits ignored.
    bus_write(BASE + 32'hC, 32'hDEAD_BEEF);
    bus_read(BASE + 32'hC, d, h);
    check("scratch", d, 32'hDEAD_BEEF);
    bus_read(BASE + 32'hF, d, h);
    check("scratch_lsb_ignored", d, 32'hDEAD_BEEF);
    bus_read(BASE, d, h);
    check("txdata_read_hit", {31'd0, h}, 32'd1);
    check("txdata_read", d, 32'd0);

    // Writes outside the window change nothing.
    bus_write(BASE + 32'h10, 32'h0000_0077);
    check("miss_hit", {31'd0, hit}, 32'd0);
    check("miss_rd", rd_data, 32'd0);
    bus_write(BASE - 32'h4, 32'h1234_5678);
    check("miss_low_hit", {31'd0, hit}, 32'd0);
    bus_read(BASE + 32'h4, d, h);
    check("miss_status", d, 32'h0000_0001);
    bus_read(BASE + 32'hC, d, h);
    check("miss_scratch", d, 32'hDEAD_BEEF);

    // Asynchronous reset mid-drain.
    bus_write(BASE, 32'h0000_0061);
    bus_write(BASE, 32'h0000_0062);
    out_ready = 1'b1;
    tick();
    check("pre_reset_head", {24'd0, out_data}, 32'h62);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_data",  {24'd0, out_data}, 32'd0);
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    bus_read(BASE + 32'h4, d, h);
    check("post_reset_status", d, 32'h0000_0001);
    bus_read(BASE + 32'hC, d, h);
    check("post_reset_scratch", d, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
